// File: rtl/muldiv_unit_if.sv
// Request/answer bundle between the exec sub-units and the shared HI/LO multiply/divide unit.
// The master side issues start pulses and operands; the slave side reports busy and read data.
interface muldiv_unit_if;
   logic        req_start;
   logic [2:0]  req_op;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic        ans_busy;
   logic [31:0] ans_data;

   modport master (
      output req_start, req_op, req_op1, req_op2,
      input  ans_busy, ans_data
   );

   modport slave (
      input  req_start, req_op, req_op1, req_op2,
      output ans_busy, ans_data
   );
endinterface

// File: rtl/muldiv_unit.sv
// MIPS32 HI/LO unit: fixed-latency multiply, 32-step restoring divide plus fix-up cycle,
// MTHI/MTLO writes, and combinational MFHI/MFLO read-back.
module muldiv_unit #(
   parameter int unsigned MUL_LATENCY = 4
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus_io
);

   localparam logic [2:0] OpMfhi  = 3'd0;
   localparam logic [2:0] OpMthi  = 3'd2;
   localparam logic [2:0] OpMtlo  = 3'd3;
   localparam logic [2:0] OpMult  = 3'd4;
   localparam logic [2:0] OpMultu = 3'd5;
   localparam logic [2:0] OpDiv   = 3'd6;
   localparam logic [2:0] OpDivu  = 3'd7;

   localparam int unsigned CntW = ($clog2(MUL_LATENCY) > 6) ? $clog2(MUL_LATENCY) : 6;
   localparam logic [CntW-1:0] MulInit = CntW'(MUL_LATENCY - 1);
   localparam logic [CntW-1:0] DivLast = CntW'(32);

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   // a_q: multiplicand, or dividend magnitude shifting into the quotient
   logic [31:0]     a_q, a_d;
   // b_q: multiplier, or divisor magnitude
   logic [31:0]     b_q, b_d;
   logic [31:0]     rem_q, rem_d;
   logic            sgn_q, sgn_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;

   logic signed [65:0] mul_a, mul_b, prod;
   logic [32:0]        rem_shift;
   logic [33:0]        diff;
   logic               fits;
   logic               div_signed;
   logic [31:0]        abs1, abs2;

   assign mul_a = {{34{sgn_q & a_q[31]}}, a_q};
   assign mul_b = {{34{sgn_q & b_q[31]}}, b_q};
   assign prod  = mul_a * mul_b;

   assign rem_shift = {rem_q, a_q[31]};
   assign diff      = {1'b0, rem_shift} - {2'b00, b_q};
   assign fits      = ~diff[33];

   assign div_signed = (bus_io.req_op == OpDiv);
   assign abs1 = (div_signed && bus_io.req_op1[31]) ? -bus_io.req_op1 : bus_io.req_op1;
   assign abs2 = (div_signed && bus_io.req_op2[31]) ? -bus_io.req_op2 : bus_io.req_op2;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;

      unique case (state_q)
         StIdle: begin
            if (bus_io.req_start) begin
               case (bus_io.req_op)
                  OpMthi: hi_d = bus_io.req_op1;
                  OpMtlo: lo_d = bus_io.req_op1;
                  OpMult, OpMultu: begin
                     a_d     = bus_io.req_op1;
                     b_d     = bus_io.req_op2;
                     sgn_d   = (bus_io.req_op == OpMult);
                     cnt_d   = MulInit;
                     state_d = StMul;
                  end
                  OpDiv, OpDivu: begin
                     a_d     = abs1;
                     b_d     = abs2;
                     rem_d   = '0;
                     qneg_d  = div_signed & (bus_io.req_op1[31] ^ bus_io.req_op2[31]);
                     rneg_d  = div_signed & bus_io.req_op1[31];
                     cnt_d   = '0;
                     state_d = StDiv;
                  end
                  default: ;
               endcase
            end
         end
         StMul: begin
            if (cnt_q == '0) begin
               {hi_d, lo_d} = prod[63:0];
               state_d      = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDiv: begin
            if (cnt_q == DivLast) begin
               // Zero divisor leaves rem = |op1|; restoring its sign reproduces op1 exactly.
               lo_d    = (b_q == '0) ? '1 : (qneg_q ? -a_q : a_q);
               hi_d    = rneg_q ? -rem_q : rem_q;
               state_d = StIdle;
            end else begin
               rem_d = fits ? diff[31:0] : rem_shift[31:0];
               a_d   = {a_q[30:0], fits};
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign bus_io.ans_busy = (state_q != StIdle);
   assign bus_io.ans_data = (bus_io.req_op == OpMfhi) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random stimulus for muldiv_unit, checked against an arithmetic model of HI/LO
// and the expected busy duration of each operation.
module tb_muldiv_unit;
   localparam int unsigned MulLat = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   muldiv_unit_if bus ();

   muldiv_unit #(.MUL_LATENCY(MulLat)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one accepted operation.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      longint      ps;
      logic [63:0] pu;
      sa = a;
      sb = b;
      case (op)
         3'd2: m_hi = a;
         3'd3: m_lo = a;
         3'd4: begin
            ps = longint'(sa) * longint'(sb);
            {m_hi, m_lo} = ps;
         end
         3'd5: begin
            pu = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = pu;
         end
         3'd6: begin
            if (b == 0) begin
               m_lo = '1; m_hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000; m_hi = '0;
            end else begin
               m_lo = sa / sb; m_hi = sa % sb;
            end
         end
         3'd7: begin
            if (b == 0) begin
               m_lo = '1; m_hi = a;
            end else begin
               m_lo = a / b; m_hi = a % b;
            end
         end
         default: ;
      endcase
   endtask

   function automatic int exp_busy(input logic [2:0] op);
      if (op == 3'd4 || op == 3'd5) return MulLat;
      if (op == 3'd6 || op == 3'd7) return 33;
      return 0;
   endfunction

   task automatic read_check(input string tag);
      bus.req_op = 3'd0;
      #1 check({tag, " HI"}, bus.ans_data, m_hi);
      bus.req_op = 3'd1;
      #1 check({tag, " LO"}, bus.ans_data, m_lo);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      int cnt;
      @(negedge clk);
      bus.req_start = 1'b1; bus.req_op = op; bus.req_op1 = a; bus.req_op2 = b;
      @(negedge clk);
      bus.req_start = 1'b0; bus.req_op = 3'd1;
      bus.req_op1 = $urandom; bus.req_op2 = $urandom;
      cnt = 0;
      while (bus.ans_busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check({tag, " busy"}, cnt, exp_busy(op));
      model(op, a, b);
      read_check(tag);
   endtask

   initial begin
      logic [31:0] old_hi, a, b;
      logic [2:0]  op;
      int          cnt;

      rst_n = 1'b0;
      bus.req_start = 1'b0; bus.req_op = 3'd0; bus.req_op1 = '0; bus.req_op2 = '0;
      #1;
      check("reset busy", 32'(bus.ans_busy), 32'd0);
      read_check("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_op("t1 mthi", 3'd2, 32'h1234_5678, 32'h0);
      run_op("t2 mult", 3'd4, 32'hFFFF_FFFF, 32'h0000_0002);
      run_op("t2 multu", 3'd5, 32'hFFFF_FFFF, 32'h0000_0002);
      run_op("t3 div", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002);
      run_op("t3 divu", 3'd7, 32'd7, 32'd2);
      run_op("t4 div ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("t4 divu zero", 3'd7, 32'h55, 32'h0);
      run_op("t4 div zero neg", 3'd6, 32'h8765_4321, 32'h0);
      run_op("mtlo", 3'd3, 32'hCAFE_F00D, 32'h0);

      // Start ignored while busy; read-back holds the pre-operation HI.
      old_hi = m_hi;
      @(negedge clk);
      bus.req_start = 1'b1; bus.req_op = 3'd4; bus.req_op1 = 32'h0001_0003; bus.req_op2 = 32'hFFFF_FFF0;
      @(negedge clk);
      bus.req_start = 1'b0;
      cnt = 0;
      while (bus.ans_busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == 2) begin
            bus.req_start = 1'b1; bus.req_op = 3'd7; bus.req_op1 = 32'h55; bus.req_op2 = 32'd3;
         end else begin
            bus.req_start = 1'b0; bus.req_op = 3'd0;
            #1;
            if (cnt == 3) check("t5 mid HI", bus.ans_data, old_hi);
         end
         @(negedge clk);
      end
      bus.req_start = 1'b0;
      check("t5 busy", cnt, MulLat);
      model(3'd4, 32'h0001_0003, 32'hFFFF_FFF0);
      @(negedge clk);
      check("t5 no second op", 32'(bus.ans_busy), 32'd0);
      read_check("t5");

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      bus.req_start = 1'b1; bus.req_op = 3'd6; bus.req_op1 = 32'd1000; bus.req_op2 = 32'd7;
      @(negedge clk);
      bus.req_start = 1'b0;
      repeat (9) @(negedge clk);
      check("t6 busy before rst", 32'(bus.ans_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("t6 busy in rst", 32'(bus.ans_busy), 32'd0);
      m_hi = '0; m_lo = '0;
      read_check("t6 in rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6 idle after rst", 32'(bus.ans_busy), 32'd0);
      run_op("t6 mtlo", 3'd3, 32'hA5A5_5A5A, 32'h0);

      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(7, 2));
         a  = $urandom;
         b  = $urandom >> $urandom_range(31, 0);
         case ($urandom_range(0, 7))
            0: b = '0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op("rand", op, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
